// File: rtl/shift_register_sequencer.sv
// ---------------------------------------------------------------------------
// shift_register_sequencer
//
// Sequencer for an external WIDTH-bit bidirectional serial shift register.
// On start it serially loads a user pattern MSB-first, then rotates it left
// (dir=0) or right (dir=1) for a programmed number of steps, or continuously
// (steps=0) until stop. Shifts are paced by an internal tick prescaler of
// TICK_DIV system clocks. A shadow copy of the register is kept in q_model.
//
// Ports:
//   clk       system clock, rising edge
//   clear     asynchronous active-low reset
//   start     one-cycle request to begin a sequence (accepted only in IDLE)
//   stop      one-cycle abort (honoured in LOAD and RUN)
//   dir       rotate direction, latched at start (0 toward MSB, 1 toward LSB)
//   pattern   value to load, latched at start
//   steps     rotate step count, latched at start (0 = continuous)
//   data      serial data to the register (registered)
//   mode      direction select to the register (registered)
//   shift_en  one-cycle shift strobe, equal to the prescaler tick
//   busy      high in LOAD and RUN
//   done      one-cycle pulse when a counted rotation completes
//   q_model   shadow of the register contents
//   state     IDLE=0, LOAD=1, RUN=2, DONE=3
// ---------------------------------------------------------------------------
module shift_register_sequencer #(
    parameter int TICK_DIV = 100000000,
    parameter int WIDTH    = 4
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             start,
    input  logic             stop,
    input  logic             dir,
    input  logic [WIDTH-1:0] pattern,
    input  logic [3:0]       steps,
    output logic             data,
    output logic             mode,
    output logic             shift_en,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q_model,
    output logic [1:0]       state
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int LW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [LW-1:0] LOAD_LAST = LW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           st_q, st_d;
    logic [TW-1:0]    tick_cnt_q, tick_cnt_d;
    logic [LW-1:0]    load_cnt_q, load_cnt_d;
    logic [3:0]       step_cnt_q, step_cnt_d;
    logic [WIDTH-1:0] pattern_l_q, pattern_l_d;
    logic             dir_l_q, dir_l_d;
    logic [3:0]       steps_l_q, steps_l_d;
    logic [WIDTH-1:0] q_d;
    logic             data_d, mode_d;
    logic             tick;
    logic [3:0]       step_inc;
    logic [LW-1:0]    bit_idx;

    assign busy     = (st_q == LOAD) || (st_q == RUN);
    assign tick     = busy && (tick_cnt_q == TICK_LAST);
    assign shift_en = tick;
    assign done     = (st_q == DONE);
    assign state    = st_q;
    assign step_inc = step_cnt_q + 4'd1;

    always_comb begin
        st_d        = st_q;
        tick_cnt_d  = '0;
        load_cnt_d  = load_cnt_q;
        step_cnt_d  = step_cnt_q;
        pattern_l_d = pattern_l_q;
        dir_l_d     = dir_l_q;
        steps_l_d   = steps_l_q;
        q_d         = q_model;
        data_d      = 1'b0;
        mode_d      = 1'b0;
        bit_idx     = '0;

        // Prescaler only runs while busy; leaving IDLE always starts it from 0.
        if (busy) begin
            tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
        end

        // The shadow follows the register even on a tick that coincides with stop.
        if (tick) begin
            q_d = mode ? {data, q_model[WIDTH-1:1]} : {q_model[WIDTH-2:0], data};
        end

        case (st_q)
            IDLE: begin
                if (start && !stop) begin
                    st_d        = LOAD;
                    pattern_l_d = pattern;
                    dir_l_d     = dir;
                    steps_l_d   = steps;
                    load_cnt_d  = '0;
                end
            end
            LOAD: begin
                if (stop) begin
                    st_d = IDLE;
                end else if (tick) begin
                    if (load_cnt_q == LOAD_LAST) begin
                        st_d       = RUN;
                        step_cnt_d = 4'd0;
                    end else begin
                        load_cnt_d = load_cnt_q + LW'(1);
                    end
                end
            end
            RUN: begin
                if (stop) begin
                    st_d = IDLE;
                end else if (tick) begin
                    step_cnt_d = step_inc;
                    if ((steps_l_q != 4'd0) && (step_inc == steps_l_q)) begin
                        st_d = DONE;
                    end
                end
            end
            default: begin
                st_d = IDLE;
            end
        endcase

        // data/mode are computed from next-cycle state so the registered
        // outputs are already valid for the whole following tick window.
        bit_idx = LOAD_LAST - load_cnt_d;
        case (st_d)
            LOAD: begin
                data_d = pattern_l_d[bit_idx];
            end
            RUN: begin
                mode_d = dir_l_d;
                data_d = dir_l_d ? q_d[0] : q_d[WIDTH-1];
            end
            default: begin
                data_d = 1'b0;
                mode_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            st_q        <= IDLE;
            tick_cnt_q  <= '0;
            load_cnt_q  <= '0;
            step_cnt_q  <= '0;
            pattern_l_q <= '0;
            dir_l_q     <= 1'b0;
            steps_l_q   <= '0;
            q_model     <= '0;
            data        <= 1'b0;
            mode        <= 1'b0;
        end else begin
            st_q        <= st_d;
            tick_cnt_q  <= tick_cnt_d;
            load_cnt_q  <= load_cnt_d;
            step_cnt_q  <= step_cnt_d;
            pattern_l_q <= pattern_l_d;
            dir_l_q     <= dir_l_d;
            steps_l_q   <= steps_l_d;
            q_model     <= q_d;
            data        <= data_d;
            mode        <= mode_d;
        end
    end

endmodule

// File: tb/tb_shift_register_sequencer.sv
// ---------------------------------------------------------------------------
// tb_shift_register_sequencer
//
// Scoreboard bench for shift_register_sequencer (TICK_DIV=4, WIDTH=4).
// The stimulus task predicts every shift_en and done event of a sequence
// (cycle, data, mode, resulting q_model and state) from the behavioural
// rules and pushes them into a queue; the monitor pops and compares each
// time the DUT strobes shift_en or done.
// ---------------------------------------------------------------------------
module tb_shift_register_sequencer;

    localparam int TD   = 4;
    localparam int W    = 4;
    localparam int MASK = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         clear = 1'b0;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic         dir = 1'b0;
    logic [W-1:0] pattern = '0;
    logic [3:0]   steps = '0;
    logic         data, mode, shift_en, busy, done;
    logic [W-1:0] q_model;
    logic [1:0]   state;

    shift_register_sequencer #(.TICK_DIV(TD), .WIDTH(W)) dut (
        .clk      (clk),
        .clear    (clear),
        .start    (start),
        .stop     (stop),
        .dir      (dir),
        .pattern  (pattern),
        .steps    (steps),
        .data     (data),
        .mode     (mode),
        .shift_en (shift_en),
        .busy     (busy),
        .done     (done),
        .q_model  (q_model),
        .state    (state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        bit is_done;
        int cyc;
        int data;
        int mode;
        int q;
        int st;
    } exp_t;

    exp_t sb[$];
    int   mq = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int rotl(input int v, input int k);
        int kk;
        kk = k % W;
        return ((v << kk) | (v >> (W - kk))) & MASK;
    endfunction

    function automatic int rotr(input int v, input int k);
        int kk;
        kk = k % W;
        return ((v >> kk) | (v << (W - kk))) & MASK;
    endfunction

    // Monitor: compares DUT events against the scoreboard queue.
    bit   pend = 1'b0;
    int   pend_q = 0;
    int   pend_st = 0;
    exp_t me;
    always @(negedge clk) begin
        if (!clear) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                chk("q_after_tick", 32'(q_model), pend_q);
                chk("state_after_tick", 32'(state), pend_st);
                pend = 1'b0;
            end
            if (shift_en) begin
                if (sb.size() == 0) begin
                    chk("unexpected_shift_en", 1, 0);
                end else begin
                    me = sb.pop_front();
                    chk("event_is_tick", 32'(me.is_done), 0);
                    chk("tick_cycle", cyc, me.cyc);
                    chk("tick_data", 32'(data), me.data);
                    chk("tick_mode", 32'(mode), me.mode);
                    pend    = 1'b1;
                    pend_q  = me.q;
                    pend_st = me.st;
                end
            end
            if (done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    me = sb.pop_front();
                    chk("event_is_done", 32'(me.is_done), 1);
                    chk("done_cycle", cyc, me.cyc);
                    chk("done_busy_low", 32'(busy), 0);
                end
            end
        end
    end

    task automatic check_idle(input string tag);
        chk({tag, "_state"}, 32'(state), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_data"}, 32'(data), 0);
        chk({tag, "_mode"}, 32'(mode), 0);
    endtask

    // One sequence. abort_c = relative cycle (1 = first cycle after the
    // start-accept edge) in which stop is driven or reset is applied; 0 = none.
    task automatic run_seq(input logic [3:0] p, input bit d, input logic [3:0] s,
                           input int abort_c, input bit abort_rst);
        int   total, nt, base, end_c, pi, mq0, k;
        exp_t e;
        pi    = int'(p);
        mq0   = mq;
        total = (s != 0) ? TD * (W + int'(s)) : 0;
        nt    = (s != 0) ? W + int'(s) : 32'h3fffffff;
        if (abort_c != 0 && (abort_c / TD) < nt) nt = abort_c / TD;
        base  = cyc;
        for (int t = 1; t <= nt; t++) begin
            e.is_done = 1'b0;
            e.cyc     = base + TD * t;
            if (t <= W) begin
                e.data = (pi >> (W - t)) & 1;
                e.mode = 0;
                e.q    = ((mq0 << t) | (pi >> (W - t))) & MASK;
            end else begin
                k      = t - W;
                e.mode = int'(d);
                e.data = d ? (rotr(pi, k - 1) & 1) : ((rotl(pi, k - 1) >> (W - 1)) & 1);
                e.q    = d ? rotr(pi, k) : rotl(pi, k);
            end
            if (abort_c != 0 && !abort_rst && TD * t == abort_c) e.st = 0;
            else if (t < W)                                    e.st = 1;
            else if (s != 0 && t == W + int'(s))               e.st = 3;
            else                                               e.st = 2;
            sb.push_back(e);
            mq = e.q;
        end
        if (s != 0 && abort_c == 0) begin
            e.is_done = 1'b1;
            e.cyc     = base + total + 1;
            e.data = 0; e.mode = 0; e.q = 0; e.st = 0;
            sb.push_back(e);
        end

        start = 1'b1; stop = 1'b0; pattern = p; dir = d; steps = s;
        @(negedge clk);
        end_c = (abort_c != 0) ? abort_c : total;
        for (int c = 1; c <= end_c; c++) begin
            start = 1'b0;
            stop  = 1'b0;
            // Spurious starts while busy must not disturb the running sequence.
            if (c < end_c && $urandom_range(3) == 0) begin
                start   = 1'b1;
                pattern = 4'($urandom);
                dir     = 1'($urandom);
                steps   = 4'($urandom);
            end
            if (c == abort_c) begin
                if (abort_rst) begin
                    #2 clear = 1'b0;
                    #1;
                    chk("rst_data", 32'(data), 0);
                    chk("rst_mode", 32'(mode), 0);
                    chk("rst_shift_en", 32'(shift_en), 0);
                    chk("rst_busy", 32'(busy), 0);
                    chk("rst_done", 32'(done), 0);
                    chk("rst_q_model", 32'(q_model), 0);
                    chk("rst_state", 32'(state), 0);
                    @(negedge clk);
                    #2 clear = 1'b1;
                    chk("rst_sb_empty", sb.size(), 0);
                    sb.delete();
                    mq = 0;
                    for (int i = 0; i < 4; i++) begin
                        @(negedge clk);
                        check_idle("post_rst");
                    end
                    return;
                end
                stop = 1'b1;
            end
            @(negedge clk);
        end
        start = 1'b0;
        stop  = 1'b0;
        if (abort_c == 0) begin
            chk("done_state", 32'(state), 3);
            @(negedge clk);
        end
        check_idle("end_seq");
        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        chk("q_retained", 32'(q_model), mq);
    endtask

    initial begin
        int s, ab;
        clear = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_state", 32'(state), 0);
        chk("reset_q_model", 32'(q_model), 0);
        chk("reset_shift_en", 32'(shift_en), 0);
        chk("reset_done", 32'(done), 0);
        check_idle("reset");
        clear = 1'b1;
        repeat (2) @(negedge clk);
        check_idle("after_release");

        // Load 1011, continuous left rotate, stop on the 2nd rotate tick.
        run_seq(4'b1011, 1'b0, 4'd0, TD * (W + 2), 1'b0);
        // Counted rotates.
        run_seq(4'b0001, 1'b0, 4'd3, 0, 1'b0);
        run_seq(4'b0001, 1'b1, 4'd2, 0, 1'b0);
        // 20 continuous rotate ticks, stop on the 20th.
        run_seq(4'b1000, 1'b0, 4'd0, TD * (W + 20), 1'b0);
        chk("rot20_q", 32'(q_model), 32'b1000);

        // start together with stop in IDLE is not accepted.
        start = 1'b1; stop = 1'b1; pattern = 4'b0110; dir = 1'b1; steps = 4'd5;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        for (int i = 0; i < 2 * TD; i++) begin
            chk("start_stop_idle_state", 32'(state), 0);
            chk("start_stop_idle_busy", 32'(busy), 0);
            @(negedge clk);
        end

        // Reset applied mid-RUN.
        run_seq(4'b1010, 1'b1, 4'd0, TD * 7 + 2, 1'b1);

        for (int n = 0; n < 10; n++) begin
            s = $urandom_range(15);
            if (s == 0)                  ab = $urandom_range(TD * (W + 10), 1);
            else if ($urandom_range(1))  ab = $urandom_range(TD * (W + s) - 1, 1);
            else                         ab = 0;
            run_seq(4'($urandom), 1'($urandom), 4'(s), ab, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
